// File: rtl/sr_flop_bank_pkg.sv
// Shared definitions for the SR flop bank: conflict-resolution mode codes
// and the per-channel next-state function.
package sr_flop_bank_pkg;

  localparam int SR_SET_PRI = 0;
  localparam int SR_RST_PRI = 1;
  localparam int SR_HOLD    = 2;
  localparam int SR_TOGGLE  = 3;

  // Next Q for one channel. s and r are decoded active-high requests.
  function automatic logic sr_next(input int mode, input logic q,
                                   input logic s, input logic r);
    logic nq;
    nq = q;
    case ({s, r})
      2'b10: nq = 1'b1;
      2'b01: nq = 1'b0;
      2'b11: begin
        case (mode)
          SR_SET_PRI: nq = 1'b1;
          SR_RST_PRI: nq = 1'b0;
          SR_TOGGLE:  nq = ~q;
          default:    nq = q;
        endcase
      end
      default: nq = q;
    endcase
    return nq;
  endfunction

endpackage

// File: rtl/sr_flop_bank_if.sv
// Signal bundle between the SR flop bank and its user.
// No valid/ready handshake: every input is sampled on each rising clock edge
// and every output is a register output, valid in every cycle.
interface sr_flop_bank_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic             en;
  logic [WIDTH-1:0] sbar;
  logic [WIDTH-1:0] rbar;
  logic             clr_cnt;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qbar;
  logic [WIDTH-1:0] conflict;
  logic [CNT_W-1:0] conflict_cnt;

  modport master (
    output en, sbar, rbar, clr_cnt,
    input  q, qbar, conflict, conflict_cnt
  );

  modport slave (
    input  en, sbar, rbar, clr_cnt,
    output q, qbar, conflict, conflict_cnt
  );
endinterface

// File: rtl/sr_flop_bank_cell.sv
// One SR storage channel: request decode (level or edge), Q register and
// registered conflict flag.
module sr_cell
  import sr_flop_bank_pkg::*;
#(
  parameter int MODE = SR_SET_PRI,
  parameter int EDGE = 0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_sbar,
  input  logic i_rbar,
  output logic o_q,
  output logic o_conflict,
  output logic o_conflict_req
);

  logic r_q;
  logic r_conflict;
  logic w_s;
  logic w_r;
  logic w_conflict_req;

  if (EDGE != 0) begin : g_edge
    logic r_prev_s;
    logic r_prev_r;
    logic r_armed;

    // r_armed blocks the first post-reset cycle so a line held low through
    // reset release is not mistaken for a falling edge.
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_prev_s <= 1'b1;
        r_prev_r <= 1'b1;
        r_armed  <= 1'b0;
      end else begin
        r_prev_s <= i_sbar;
        r_prev_r <= i_rbar;
        r_armed  <= 1'b1;
      end
    end

    assign w_s = r_armed & r_prev_s & ~i_sbar;
    assign w_r = r_armed & r_prev_r & ~i_rbar;
  end else begin : g_level
    assign w_s = ~i_sbar;
    assign w_r = ~i_rbar;
  end

  assign w_conflict_req = i_en & w_s & w_r;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q        <= 1'b0;
      r_conflict <= 1'b0;
    end else begin
      r_conflict <= w_conflict_req;
      if (i_en) r_q <= sr_next(MODE, r_q, w_s, w_r);
    end
  end

  assign o_q            = r_q;
  assign o_conflict     = r_conflict;
  assign o_conflict_req = w_conflict_req;

endmodule

// File: rtl/sr_flop_bank.sv
// WIDTH clocked SR channels with selectable conflict resolution, optional
// edge triggering, global enable and a saturating conflict counter.
module sr_flop_bank
  import sr_flop_bank_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int MODE  = SR_SET_PRI,
  parameter int EDGE  = 0,
  parameter int CNT_W = 8
) (
  input logic            i_clk,
  input logic            i_rst,
  sr_flop_bank_if.slave  bus
);

  if (MODE < SR_SET_PRI || MODE > SR_TOGGLE) begin : g_bad_mode
    $error("sr_flop_bank: MODE must be 0..3, got %0d", MODE);
  end

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_conflict;
  logic [WIDTH-1:0] w_conflict_req;
  logic             w_any_conflict;
  logic [CNT_W-1:0] r_cnt;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    sr_cell #(
      .MODE (MODE),
      .EDGE (EDGE)
    ) u_cell (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .i_en           (bus.en),
      .i_sbar         (bus.sbar[i]),
      .i_rbar         (bus.rbar[i]),
      .o_q            (w_q[i]),
      .o_conflict     (w_conflict[i]),
      .o_conflict_req (w_conflict_req[i])
    );
  end

  // Several channels conflicting in the same cycle count as one event.
  assign w_any_conflict = |w_conflict_req;

  always_ff @(posedge i_clk) begin
    if (i_rst || bus.clr_cnt) begin
      r_cnt <= '0;
    end else if (w_any_conflict && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign bus.q            = w_q;
  assign bus.qbar         = ~w_q;
  assign bus.conflict     = w_conflict;
  assign bus.conflict_cnt = r_cnt;

endmodule

// File: tb/tb_sr_flop_bank.sv
// Bench for sr_flop_bank: six 4-channel instances (modes 0-3 level, mode 0
// edge, mode 0 with a 2-bit counter) share one stimulus stream.
module tb_sr_flop_bank;
  import sr_flop_bank_pkg::*;

  localparam int NDUT = 6;

  typedef struct {
    int         id;
    string      name;
    logic [3:0] q;
    logic [3:0] conf;
    logic [7:0] cnt;
  } exp_t;

  // ---------------- clock / reset / shared stimulus ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] sbar;
  logic [3:0] rbar;
  logic       clr;

  always #5 clk = ~clk;

  logic [3:0] act_q    [NDUT];
  logic [3:0] act_qbar [NDUT];
  logic [3:0] act_conf [NDUT];
  logic [7:0] act_cnt  [NDUT];

  for (genvar g = 0; g < 5; g++) begin : g_dut
    sr_flop_bank_if #(.WIDTH(4), .CNT_W(8)) bus ();
    sr_flop_bank #(
      .WIDTH (4),
      .MODE  (g < 4 ? g : 0),
      .EDGE  (g == 4 ? 1 : 0),
      .CNT_W (8)
    ) u_dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
    );
    assign bus.en      = en;
    assign bus.sbar    = sbar;
    assign bus.rbar    = rbar;
    assign bus.clr_cnt = clr;
    assign act_q[g]    = bus.q;
    assign act_qbar[g] = bus.qbar;
    assign act_conf[g] = bus.conflict;
    assign act_cnt[g]  = bus.conflict_cnt;
  end

  sr_flop_bank_if #(.WIDTH(4), .CNT_W(2)) bus_c2 ();
  sr_flop_bank #(
    .WIDTH (4),
    .MODE  (SR_SET_PRI),
    .EDGE  (0),
    .CNT_W (2)
  ) u_dut_c2 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus_c2)
  );
  assign bus_c2.en      = en;
  assign bus_c2.sbar    = sbar;
  assign bus_c2.rbar    = rbar;
  assign bus_c2.clr_cnt = clr;
  assign act_q[5]       = bus_c2.q;
  assign act_qbar[5]    = bus_c2.qbar;
  assign act_conf[5]    = bus_c2.conflict;
  assign act_cnt[5]     = {6'b0, bus_c2.conflict_cnt};

  // ---------------- scoreboard ----------------
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input int id, input string fld,
                     input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s dut%0d %s: got %h expected %h", name, id, fld, act, exp);
    end
  endtask

  // Outputs are registered; every edge presents a new result, so the
  // monitor drains everything queued before that edge.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk(e.name, e.id, "q",    {4'b0, act_q[e.id]},    {4'b0, e.q});
      chk(e.name, e.id, "qbar", {4'b0, act_qbar[e.id]}, {4'b0, ~e.q});
      chk(e.name, e.id, "conf", {4'b0, act_conf[e.id]}, {4'b0, e.conf});
      chk(e.name, e.id, "cnt",  act_cnt[e.id],          e.cnt);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push(input int id, input string name, input logic [3:0] q,
                      input logic [3:0] conf, input logic [7:0] cnt);
    exp_t e;
    e.id = id; e.name = name; e.q = q; e.conf = conf; e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  // q0..q3: level modes 0..3; dut5 mirrors dut0 Q/CONFLICT with its own count.
  task automatic exp_all(input string name,
                         input logic [3:0] q0, input logic [3:0] q1,
                         input logic [3:0] q2, input logic [3:0] q3,
                         input logic [3:0] conf, input logic [7:0] cnt,
                         input logic [7:0] cnt5, input logic [3:0] q4,
                         input logic [3:0] conf4, input logic [7:0] cnt4);
    push(0, name, q0, conf, cnt);
    push(1, name, q1, conf, cnt);
    push(2, name, q2, conf, cnt);
    push(3, name, q3, conf, cnt);
    push(4, name, q4, conf4, cnt4);
    push(5, name, q0, conf, cnt5);
  endtask

  task automatic step(input logic e, input logic [3:0] s, input logic [3:0] r,
                      input logic c, input logic rs);
    en = e; sbar = s; rbar = r; clr = c; rst = rs;
    @(posedge clk);
    #2;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1; en = 1'b1; sbar = 4'h0; rbar = 4'hF; clr = 1'b0;

    exp_all("rst1", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 8'd0, 8'd0, 4'h0, 4'h0, 8'd0);
    step(1'b1, 4'h0, 4'hF, 1'b0, 1'b1);
    exp_all("rst2", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 8'd0, 8'd0, 4'h0, 4'h0, 8'd0);
    step(1'b1, 4'h0, 4'hF, 1'b0, 1'b1);
    exp_all("rst_rel", 4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 8'd0, 8'd0, 4'h0, 4'h0, 8'd0);
    step(1'b1, 4'h0, 4'hF, 1'b0, 1'b0);

    exp_all("clr_all", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 8'd0, 8'd0, 4'h0, 4'h0, 8'd0);
    step(1'b1, 4'hF, 4'h0, 1'b0, 1'b0);
    exp_all("set0", 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 8'd0, 8'd0, 4'h1, 4'h0, 8'd0);
    step(1'b1, 4'hE, 4'hF, 1'b0, 1'b0);
    exp_all("reset0", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 8'd0, 8'd0, 4'h0, 4'h0, 8'd0);
    step(1'b1, 4'hF, 4'hE, 1'b0, 1'b0);
    exp_all("hold", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 8'd0, 8'd0, 4'h0, 4'h0, 8'd0);
    step(1'b1, 4'hF, 4'hF, 1'b0, 1'b0);

    exp_all("conf1", 4'hF, 4'h0, 4'h0, 4'hF, 4'hF, 8'd1, 8'd1, 4'hF, 4'hF, 8'd1);
    step(1'b1, 4'h0, 4'h0, 1'b0, 1'b0);
    exp_all("conf2", 4'hF, 4'h0, 4'h0, 4'h0, 4'hF, 8'd2, 8'd2, 4'hF, 4'h0, 8'd1);
    step(1'b1, 4'h0, 4'h0, 1'b0, 1'b0);
    exp_all("conf3", 4'hF, 4'h0, 4'h0, 4'hF, 4'hF, 8'd3, 8'd3, 4'hF, 4'h0, 8'd1);
    step(1'b1, 4'h0, 4'h0, 1'b0, 1'b0);
    exp_all("conf_off", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 8'd3, 8'd3, 4'hF, 4'h0, 8'd1);
    step(1'b1, 4'hF, 4'h0, 1'b0, 1'b0);
    exp_all("conf4", 4'hF, 4'h0, 4'h0, 4'hF, 4'hF, 8'd4, 8'd3, 4'hF, 4'h0, 8'd1);
    step(1'b1, 4'h0, 4'h0, 1'b0, 1'b0);
    exp_all("conf5_sat", 4'hF, 4'h0, 4'h0, 4'h0, 4'hF, 8'd5, 8'd3, 4'hF, 4'h0, 8'd1);
    step(1'b1, 4'h0, 4'h0, 1'b0, 1'b0);
    exp_all("clr_vs_inc", 4'hF, 4'h0, 4'h0, 4'hF, 4'hF, 8'd0, 8'd0, 4'hF, 4'h0, 8'd0);
    step(1'b1, 4'h0, 4'h0, 1'b1, 1'b0);
    exp_all("post_clr", 4'hF, 4'h0, 4'h0, 4'hF, 4'h0, 8'd0, 8'd0, 4'hF, 4'h0, 8'd0);
    step(1'b1, 4'hF, 4'hF, 1'b0, 1'b0);

    exp_all("edge_clr", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 8'd0, 8'd0, 4'h0, 4'h0, 8'd0);
    step(1'b1, 4'hF, 4'h0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      exp_all("s0_held", 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 8'd0, 8'd0, 4'h1, 4'h0, 8'd0);
      step(1'b1, 4'hE, 4'hF, 1'b0, 1'b0);
    end
    exp_all("r0_pulse", 4'h1, 4'h0, 4'h1, 4'h0, 4'h1, 8'd1, 8'd1, 4'h0, 4'h0, 8'd0);
    step(1'b1, 4'hE, 4'hE, 1'b0, 1'b0);
    exp_all("no_reset_again", 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 8'd1, 8'd1, 4'h0, 4'h0, 8'd0);
    step(1'b1, 4'hE, 4'hF, 1'b0, 1'b0);
    exp_all("idle", 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 8'd1, 8'd1, 4'h0, 4'h0, 8'd0);
    step(1'b1, 4'hF, 4'hF, 1'b0, 1'b0);

    exp_all("en0_conf", 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 8'd1, 8'd1, 4'h0, 4'h0, 8'd0);
    step(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    exp_all("en0_set", 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 8'd1, 8'd1, 4'h0, 4'h0, 8'd0);
    step(1'b0, 4'h0, 4'hF, 1'b0, 1'b0);
    exp_all("en1_set", 4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 8'd1, 8'd1, 4'h0, 4'h0, 8'd0);
    step(1'b1, 4'h0, 4'hF, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    #3;
    chk("drain", 0, "pending", 8'(exp_q.size()), 8'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
